// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported data memory.
// Each access runs IDLE -> ACCESS -> RESP, so one access completes every 3 cycles.
// Build macro DMEM_ARB_ROUND_ROBIN_EN: on contention, grant the port that was not
// granted last. Without it, port 0 always wins contention.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

    state_t state;
    // Last-granted port; it also identifies the owner of the access in flight.
    logic   last_gnt;
    logic   pick_p1;
    logic   grant;

    // Arbitration: choose the winner and issue the combinational grant pulse.
    always_comb begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        pick_p1 = p1_req & (~p0_req | ~last_gnt);
`else
        pick_p1 = p1_req & ~p0_req;
`endif
        grant  = (state == StIdle) & ~rst & (p0_req | p1_req);
        p0_gnt = grant & ~pick_p1;
        p1_gnt = grant & pick_p1;
    end

    assign busy = (state != StIdle);

    // Access FSM; memory strobes, address/data, read data and rvalid are all registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            last_gnt  <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            case (state)
                StIdle: begin
                    if (grant) begin
                        state     <= StAccess;
                        last_gnt  <= pick_p1;
                        mem_addr  <= pick_p1 ? p1_addr : p0_addr;
                        mem_wdata <= pick_p1 ? p1_wdata : p0_wdata;
                        mem_we    <= pick_p1 ? p1_we : p0_we;
                        mem_re    <= pick_p1 ? ~p1_we : ~p0_we;
                    end
                end
                StAccess: begin
                    state <= StResp;
                    // mem_re is high only during ACCESS of a read.
                    if (mem_re) begin
                        if (last_gnt) begin
                            p1_rdata  <= mem_rdata;
                            p1_rvalid <= 1'b1;
                        end else begin
                            p0_rdata  <= mem_rdata;
                            p0_rvalid <= 1'b1;
                        end
                    end
                end
                StResp: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model of the arbiter.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [15:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [15:0] p0_rdata, p1_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re, busy;
    logic        mem_load = 1'b1;
    logic [15:0] mem [16];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Small data memory; mem_load restores the known contents mem[i] = i + 1.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'(i + 1);
        end else if (mem_we) begin
            mem[mem_addr[3:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[3:0]];

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [15:0] a, input logic [15:0] d);
        if (p == 0) begin
            p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
        end else begin
            p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
        end
    endtask

    task automatic reset_dut();
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        mem_load = 1'b1;
        step();
        rst = 1'b0;
        mem_load = 1'b0;
    endtask

    // One uncontended access starting in IDLE; ends at the next IDLE cycle.
    task automatic xfer(input int p, input logic we, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] exp_rd);
        drive(p, 1'b1, we, a, d);
        #1;
        chk("gnt_p0", p0_gnt, p == 0);
        chk("gnt_p1", p1_gnt, p == 1);
        chk("idle_we", mem_we, 1'b0);
        step();
        drive(p, 1'b0, we, a, d);
        #1;
        chk("acc_we", mem_we, we);
        chk("acc_re", mem_re, !we);
        chk("acc_addr", mem_addr, a);
        chk("acc_wdata", mem_wdata, d);
        chk("acc_busy", busy, 1'b1);
        chk("acc_nognt", p0_gnt | p1_gnt, 1'b0);
        step();
        chk("resp_rv0", p0_rvalid, (p == 0) && !we);
        chk("resp_rv1", p1_rvalid, (p == 1) && !we);
        chk("resp_rdata", (p == 0) ? p0_rdata : p1_rdata, exp_rd);
        chk("resp_we", mem_we, 1'b0);
        chk("resp_re", mem_re, 1'b0);
        chk("resp_busy", busy, 1'b1);
        step();
        chk("done_busy", busy, 1'b0);
        chk("done_rv", p0_rvalid | p1_rvalid, 1'b0);
    endtask

    // Reference model state for the randomized run.
    logic [15:0] ref_mem [16];
    logic        pend [2];
    logic        rwe [2];
    logic [15:0] raddr [2];
    logic [15:0] rwd [2];
    logic [15:0] exp_rd [2];
    logic [15:0] exp_addr, exp_wdata, acc_data;
    logic        acc_we;
    int          acc_port, last, g, win;
    bit          in_acc, in_resp;

    initial begin
        // Reset state, and no grant while rst is high even with a request pending.
        step();
        p0_req = 1'b1;
        #1;
        chk("rst_nognt", p0_gnt | p1_gnt, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_re", mem_re, 1'b0);
        chk("rst_addr", mem_addr, 16'h0);
        chk("rst_wdata", mem_wdata, 16'h0);
        chk("rst_rd0", p0_rdata, 16'h0);
        chk("rst_rd1", p1_rdata, 16'h0);
        chk("rst_rv", p0_rvalid | p1_rvalid, 1'b0);
        p0_req = 1'b0;
        rst = 1'b0;
        mem_load = 1'b0;
        step();

        // Single read of addr 3, then write 0x00AB to addr 5 and read it back.
        xfer(0, 1'b0, 16'd3, 16'h0, 16'h0004);
        xfer(1, 1'b1, 16'd5, 16'h00AB, 16'h0000);
        xfer(1, 1'b0, 16'd5, 16'h0000, 16'h00AB);

        // Contention: both ports hold req through four accesses.
        reset_dut();
        drive(0, 1'b1, 1'b0, 16'd1, 16'h0);
        drive(1, 1'b1, 1'b0, 16'd2, 16'h0);
        for (int c = 0; c < 12; c++) begin
            #1;
            chk("cont_gnt0", p0_gnt, (c % 3 == 0) && (!RR || ((c / 3) % 2 == 0)));
            chk("cont_gnt1", p1_gnt, (c % 3 == 0) && RR && ((c / 3) % 2 == 1));
            step();
        end
        drive(0, 1'b0, 1'b0, 16'd1, 16'h0);
        drive(1, 1'b0, 1'b0, 16'd2, 16'h0);
        chk("cont_rd0", p0_rdata, 16'h0002);

        // Reset during ACCESS of a p0 read of addr 2 abandons it.
        drive(0, 1'b1, 1'b0, 16'd2, 16'h0);
        #1;
        chk("rmid_gnt", p0_gnt, 1'b1);
        step();
        drive(0, 1'b0, 1'b0, 16'd2, 16'h0);
        rst = 1'b1;
        #1;
        chk("rmid_acc", mem_re, 1'b1);
        step();
        rst = 1'b0;
        chk("rmid_rv", p0_rvalid, 1'b0);
        chk("rmid_rd", p0_rdata, 16'h0);
        chk("rmid_busy", busy, 1'b0);
        chk("rmid_re", mem_re, 1'b0);
        step();
        chk("rmid_rv2", p0_rvalid, 1'b0);

        // Idle for 10 cycles.
        for (int c = 0; c < 10; c++) begin
            step();
            chk("idle_we", mem_we, 1'b0);
            chk("idle_re", mem_re, 1'b0);
            chk("idle_gnt", p0_gnt | p1_gnt, 1'b0);
            chk("idle_rv", p0_rvalid | p1_rvalid, 1'b0);
            chk("idle_busy", busy, 1'b0);
        end

        // Randomized traffic against the reference model.
        reset_dut();
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'(i + 1);
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; rwe[p] = 1'b0; raddr[p] = '0; rwd[p] = '0; exp_rd[p] = '0;
        end
        exp_addr = '0; exp_wdata = '0; acc_data = '0; acc_we = 1'b0;
        acc_port = 0; last = 1; g = -10;
        for (int c = 0; c < 400; c++) begin
            step();
            in_acc  = (c == g + 1);
            in_resp = (c == g + 2);
            if (in_resp && !acc_we) exp_rd[acc_port] = acc_data;
            chk("rnd_busy", busy, in_acc || in_resp);
            chk("rnd_we", mem_we, in_acc && acc_we);
            chk("rnd_re", mem_re, in_acc && !acc_we);
            chk("rnd_addr", mem_addr, exp_addr);
            chk("rnd_wdata", mem_wdata, exp_wdata);
            chk("rnd_rv0", p0_rvalid, in_resp && !acc_we && acc_port == 0);
            chk("rnd_rv1", p1_rvalid, in_resp && !acc_we && acc_port == 1);
            chk("rnd_rd0", p0_rdata, exp_rd[0]);
            chk("rnd_rd1", p1_rdata, exp_rd[1]);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p]  = 1'b1;
                    rwe[p]   = 1'($urandom_range(0, 1));
                    raddr[p] = 16'($urandom_range(0, 15));
                    rwd[p]   = 16'($urandom);
                end
                drive(p, pend[p], rwe[p], raddr[p], rwd[p]);
            end
            #1;
            win = -1;
            if (c >= g + 3) begin
                if (pend[0] && pend[1]) win = (RR && last == 0) ? 1 : 0;
                else if (pend[0]) win = 0;
                else if (pend[1]) win = 1;
            end
            chk("rnd_gnt0", p0_gnt, win == 0);
            chk("rnd_gnt1", p1_gnt, win == 1);
            if (win >= 0) begin
                g         = c;
                acc_port  = win;
                last      = win;
                acc_we    = rwe[win];
                exp_addr  = raddr[win];
                exp_wdata = rwd[win];
                if (acc_we) ref_mem[raddr[win][3:0]] = rwd[win];
                else acc_data = ref_mem[raddr[win][3:0]];
                pend[win] = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, width of every address bus.
REQ-002 SHALL have parameter DATA_W, default 16, width of every data bus.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports p0_req/p1_req  input  1  access request, held until the matching grant.
REQ-006 SHALL have ports p0_we/p1_we  input  1  1 = write, 0 = read; stable while req is high.
REQ-007 SHALL have ports p0_addr/p1_addr  input  ADDR_W  access address; stable while req is high.
REQ-008 SHALL have ports p0_wdata/p1_wdata  input  DATA_W  write data; stable while req is high.
REQ-009 SHALL have ports p0_gnt/p1_gnt  output  1  one-cycle grant pulse; the request is accepted.
REQ-010 SHALL have ports p0_rvalid/p1_rvalid  output  1  one-cycle read-data-valid pulse.
REQ-011 SHALL have ports p0_rdata/p1_rdata  output  DATA_W  registered read data, held until that port's next read completes.
REQ-012 SHALL have ports mem_addr, mem_wdata  output  ADDR_W/DATA_W  data memory address and write data.
REQ-013 SHALL have ports mem_we, mem_re  output  1  data memory write and read strobes.
REQ-014 SHALL have port mem_rdata  input  DATA_W  combinational read data from the data memory.
REQ-015 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; each of ACCESS and RESP lasts exactly one cycle.
REQ-017 In IDLE, if any req is high, the arbiter SHALL pulse exactly one gnt, latch that port's we/addr/wdata and a port ID, and move to ACCESS.
REQ-018 In IDLE with no req, the FSM SHALL stay in IDLE with all gnt low.
REQ-019 gnt SHALL be asserted combinationally in the IDLE cycle where req is sampled; the requester SHALL drop or change req on the cycle after gnt.
REQ-020 In ACCESS, mem_addr/mem_wdata SHALL carry the latched values, with mem_we = latched we and mem_re = not latched we, for one cycle.
REQ-021 Outside ACCESS, mem_we and mem_re SHALL be 0; mem_addr and mem_wdata SHALL hold their last values.
REQ-022 For a read, mem_rdata SHALL be registered into the owning port's rdata at the end of ACCESS, and rvalid SHALL pulse during RESP; grant-to-rvalid latency = 2 cycles.
REQ-023 For a write, no rvalid SHALL pulse, and rdata of both ports SHALL be unchanged.
REQ-024 No gnt SHALL be issued in ACCESS or RESP; a req arriving then waits and is arbitrated in the next IDLE cycle.
REQ-025 Peak throughput SHALL be one access per 3 cycles; a port with continuous req SHALL be granted at most every 3 cycles.
REQ-026 The arbiter SHALL record the last-granted port (last_gnt) on every grant.

Reset
REQ-027 While rst is high at a clock edge, the following SHALL hold on the next cycle: state = IDLE, every gnt/rvalid = 0, mem_we = mem_re = 0, mem_addr = mem_wdata = 0, p0_rdata = p1_rdata = 0, busy = 0, last_gnt = port 1.
REQ-028 rst asserted during ACCESS or RESP SHALL abandon the access with no rvalid; a write whose ACCESS cycle coincides with the rst edge has already been presented to memory and is not retracted.
REQ-029 While rst is high, no gnt SHALL be issued.

Configuration
REQ-030 Macro DMEM_ARB_ROUND_ROBIN_EN defined: when both reqs are high in IDLE, the port that is not last_gnt SHALL be granted; port 0 wins the first contention after reset.
REQ-031 Macro DMEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins contention; last_gnt is still maintained but SHALL NOT affect arbitration.

Verification
REQ-032 Single read: p0 reads addr 3 with mem[3]=0x0004 -> p0_gnt in cycle 0, mem_re=1 with mem_addr=3 in cycle 1, p0_rvalid=1 with p0_rdata=0x0004 in cycle 2.
REQ-033 Write then read back: p1 writes 0x00AB to addr 5, then reads addr 5 -> exactly one mem_we pulse and no p1_rvalid for the write; the read returns p1_rdata=0x00AB.
REQ-034 Contention with round-robin built in: both ports hold req for 4 accesses -> grant order p0, p1, p0, p1, with grants 3 cycles apart.
REQ-035 Contention with the macro undefined: same stimulus as REQ-034 -> p0 granted every time and p1 never granted while p0_req stays high.
REQ-036 Reset mid-read: rst asserted in the ACCESS cycle of a p0 read of addr 2 -> no p0_rvalid; p0_rdata=0, busy=0 and state IDLE on the next cycle.
REQ-037 Idle: no req for 10 cycles -> mem_we, mem_re, every gnt, every rvalid and busy all remain 0.
